// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the bundle
// of per-stage hold/bubble controls.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_WAIT  = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic flush_id;
      logic flush_ex;
      logic flush_mem;
      logic flush_wb;
      logic md_start;
   } ctrl_t;

endpackage

// File: rtl/wait_timer.sv
// Counts cycles spent in a wait state and raises a sticky error once the
// count reaches WAIT_MAX. Only rst clears the error.
module wait_timer #(
   parameter int WAIT_MAX = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   output logic err
);

   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   // A new wait episode restarts the count even if the previous one was still counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
      err_d = err_q | (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves load-use,
// redirect, multi-cycle MUL/DIV and data-memory wait hazards.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       MemRead_ex,
   input  logic [4:0] rdAddr_ex,
   input  logic [4:0] rs1Addr_id,
   input  logic [4:0] rs2Addr_id,
   input  logic       rs1Used_id,
   input  logic       rs2Used_id,
   input  logic       BranchTaken_ex,
   input  logic       MulDiv_ex,
   input  logic       md_done,
   input  logic       dmem_req_mem,
   input  logic       dmem_ready,
   output logic       Stall_if,
   output logic       Stall_id,
   output logic       Stall_ex,
   output logic       Stall_mem,
   output logic       Flush_id,
   output logic       Flush_ex,
   output logic       Flush_mem,
   output logic       Flush_wb,
   output logic       md_start,
   output logic       busy,
   output logic       wait_err
);

   state_e state_q, state_d;
   logic   busy_q;
   ctrl_t  ctrl;
   logic   load_use;
   logic   tail_en;
   logic   tmr_clear;
   logic   tmr_count;

   assign load_use = MemRead_ex && (rdAddr_ex != REG_X0) &&
                     ((rs1Used_id && (rs1Addr_id == rdAddr_ex)) ||
                      (rs2Used_id && (rs2Addr_id == rdAddr_ex)));

   always_comb begin
      ctrl    = '0;
      state_d = state_q;
      tail_en = 1'b0;
      unique case (state_q)
         RUN: begin
            if (dmem_req_mem && !dmem_ready) begin
               ctrl.stall_if  = 1'b1;
               ctrl.stall_id  = 1'b1;
               ctrl.stall_ex  = 1'b1;
               ctrl.stall_mem = 1'b1;
               ctrl.flush_wb  = 1'b1;
               state_d        = MEM_WAIT;
            end else begin
               tail_en = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!dmem_ready) begin
               ctrl.stall_if  = 1'b1;
               ctrl.stall_id  = 1'b1;
               ctrl.stall_ex  = 1'b1;
               ctrl.stall_mem = 1'b1;
               ctrl.flush_wb  = 1'b1;
            end else begin
               state_d = RUN;
               tail_en = 1'b1;
            end
         end
         MD_WAIT: begin
            // md_done cycle releases everything so the result lands in EX/MEM.
            if (!md_done) begin
               ctrl.stall_if  = 1'b1;
               ctrl.stall_id  = 1'b1;
               ctrl.stall_ex  = 1'b1;
               ctrl.flush_mem = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      // Lower-priority rules, shared by RUN and the MEM_WAIT exit cycle.
      if (tail_en) begin
         if (MulDiv_ex) begin
            ctrl.md_start  = 1'b1;
            ctrl.stall_if  = 1'b1;
            ctrl.stall_id  = 1'b1;
            ctrl.stall_ex  = 1'b1;
            ctrl.flush_mem = 1'b1;
            state_d        = MD_WAIT;
         end else if (BranchTaken_ex) begin
            ctrl.flush_id = 1'b1;
            ctrl.flush_ex = 1'b1;
         end else if (load_use) begin
            ctrl.stall_if = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.flush_ex = 1'b1;
         end
      end

      if (rst) begin
         ctrl    = '0;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != RUN);
      end
   end

   assign tmr_clear = (state_d != RUN) && (state_d != state_q);
   assign tmr_count = (state_q != RUN);

   wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (tmr_clear),
      .count (tmr_count),
      .err   (wait_err)
   );

   assign Stall_if  = ctrl.stall_if;
   assign Stall_id  = ctrl.stall_id;
   assign Stall_ex  = ctrl.stall_ex;
   assign Stall_mem = ctrl.stall_mem;
   assign Flush_id  = ctrl.flush_id;
   assign Flush_ex  = ctrl.flush_ex;
   assign Flush_mem = ctrl.flush_mem;
   assign Flush_wb  = ctrl.flush_wb;
   assign md_start  = ctrl.md_start;
   assign busy      = busy_q && !rst;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the sequencer.
module tb_pipeline_ctrl;

   localparam int WMAX = 8;
   localparam int M_RUN = 0, M_MD = 1, M_MEM = 2;

   // Output vector order: Stall_if Stall_id Stall_ex Stall_mem Flush_id Flush_ex Flush_mem Flush_wb md_start
   localparam logic [8:0] C_NONE    = 9'b000000000;
   localparam logic [8:0] C_MEM     = 9'b111100010;
   localparam logic [8:0] C_MD      = 9'b111000101;
   localparam logic [8:0] C_MD_HOLD = 9'b111000100;
   localparam logic [8:0] C_BR      = 9'b000011000;
   localparam logic [8:0] C_LU      = 9'b110001000;

   logic       clk = 1'b0;
   logic       rst;
   logic       MemRead_ex;
   logic [4:0] rdAddr_ex, rs1Addr_id, rs2Addr_id;
   logic       rs1Used_id, rs2Used_id;
   logic       BranchTaken_ex, MulDiv_ex, md_done, dmem_req_mem, dmem_ready;
   logic       Stall_if, Stall_id, Stall_ex, Stall_mem;
   logic       Flush_id, Flush_ex, Flush_mem, Flush_wb;
   logic       md_start, busy, wait_err;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         m_mode  = M_RUN;
   int         m_waited = 0;
   bit         m_err   = 1'b0;
   logic [8:0] obs_ctrl;
   logic       obs_busy, obs_err;

   always #5 clk = ~clk;

   pipeline_ctrl #(.WAIT_MAX(WMAX)) dut (
      .clk(clk), .rst(rst),
      .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
      .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
      .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
      .BranchTaken_ex(BranchTaken_ex), .MulDiv_ex(MulDiv_ex), .md_done(md_done),
      .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
      .Stall_if(Stall_if), .Stall_id(Stall_id), .Stall_ex(Stall_ex), .Stall_mem(Stall_mem),
      .Flush_id(Flush_id), .Flush_ex(Flush_ex), .Flush_mem(Flush_mem), .Flush_wb(Flush_wb),
      .md_start(md_start), .busy(busy), .wait_err(wait_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      rst = 1'b0; MemRead_ex = 1'b0; rdAddr_ex = '0; rs1Addr_id = '0; rs2Addr_id = '0;
      rs1Used_id = 1'b0; rs2Used_id = 1'b0; BranchTaken_ex = 1'b0; MulDiv_ex = 1'b0;
      md_done = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
   endtask

   // Called at negedge+1 with inputs applied; samples, checks against the model,
   // advances the model across the next rising edge and returns at negedge+1.
   task automatic tick(input string tag);
      logic [8:0] e;
      int         nxt;
      bit         lu;
      #1;
      obs_ctrl = {Stall_if, Stall_id, Stall_ex, Stall_mem, Flush_id, Flush_ex, Flush_mem, Flush_wb, md_start};
      obs_busy = busy;
      obs_err  = wait_err;
      lu = MemRead_ex && (rdAddr_ex != 5'd0) &&
           ((rs1Used_id && rs1Addr_id == rdAddr_ex) || (rs2Used_id && rs2Addr_id == rdAddr_ex));
      e   = C_NONE;
      nxt = m_mode;
      if (rst) begin
         nxt = M_RUN;
      end else if (m_mode == M_MD) begin
         if (md_done) nxt = M_RUN;
         else e = C_MD_HOLD;
      end else if (!dmem_ready && (m_mode == M_MEM || dmem_req_mem)) begin
         e = C_MEM; nxt = M_MEM;
      end else begin
         nxt = M_RUN;
         if (MulDiv_ex) begin e = C_MD; nxt = M_MD; end
         else if (BranchTaken_ex) e = C_BR;
         else if (lu) e = C_LU;
      end
      chk({tag, "_ctrl"}, 32'(obs_ctrl), 32'(e));
      chk({tag, "_busy"}, 32'(obs_busy), 32'(!rst && m_mode != M_RUN));
      chk({tag, "_err"},  32'(obs_err),  32'(m_err));
      if (rst) begin
         m_waited = 0; m_err = 1'b0;
      end else begin
         if (nxt != M_RUN && nxt != m_mode) m_waited = 0;
         else if (m_mode != M_RUN && m_waited < WMAX) m_waited++;
         if (m_waited == WMAX) m_err = 1'b1;
      end
      m_mode = nxt;
      @(negedge clk);
      #1;
   endtask

   initial begin
      clr_in();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tick("reset");
      chk("reset_outs", 32'(obs_ctrl), 32'(C_NONE));
      chk("reset_busy", 32'(obs_busy), 32'd0);
      rst = 1'b0;
      tick("idle");
      chk("idle_err", 32'(obs_err), 32'd0);

      // Load-use on rs2 gives exactly one bubble; x0 never stalls.
      MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs2Used_id = 1'b1; rs2Addr_id = 5'd5;
      tick("lu");
      chk("lu_one", 32'(obs_ctrl), 32'(C_LU));
      clr_in();
      tick("lu_after");
      chk("lu_after", 32'(obs_ctrl), 32'(C_NONE));
      MemRead_ex = 1'b1; rs2Used_id = 1'b1;
      tick("lu_x0");
      chk("lu_x0", 32'(obs_ctrl), 32'(C_NONE));

      // Branch beats load-use.
      clr_in();
      MemRead_ex = 1'b1; rdAddr_ex = 5'd7; rs1Used_id = 1'b1; rs1Addr_id = 5'd7; BranchTaken_ex = 1'b1;
      tick("br_lu");
      chk("br_lu", 32'(obs_ctrl), 32'(C_BR));

      // MUL/DIV with md_done after 4 cycles.
      clr_in();
      MulDiv_ex = 1'b1;
      tick("md0");
      chk("md0_start", 32'(obs_ctrl), 32'(C_MD));
      for (int i = 1; i <= 3; i++) begin
         tick("md_hold");
         chk("md_hold", 32'(obs_ctrl), 32'(C_MD_HOLD));
         chk("md_busy", 32'(obs_busy), 32'd1);
      end
      md_done = 1'b1;
      tick("md_done");
      chk("md_done", 32'(obs_ctrl), 32'(C_NONE));
      chk("md_done_busy", 32'(obs_busy), 32'd1);
      clr_in();
      tick("md_exit");
      chk("md_exit_busy", 32'(obs_busy), 32'd0);

      // Memory wait with a MUL/DIV behind it.
      MulDiv_ex = 1'b1; dmem_req_mem = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("mw");
         chk("mw_flushwb", 32'(obs_ctrl), 32'(C_MEM));
      end
      dmem_ready = 1'b1;
      tick("mw_rdy");
      chk("mw_rdy_start", 32'(obs_ctrl), 32'(C_MD));
      clr_in();
      tick("mw_md");
      chk("mw_md_hold", 32'(obs_ctrl), 32'(C_MD_HOLD));
      md_done = 1'b1;
      tick("mw_md_done");
      clr_in();
      tick("mw_end");

      // Timeout: error after WMAX wait cycles, sticky until rst.
      dmem_req_mem = 1'b1;
      for (int i = 0; i < WMAX + 2; i++) begin
         tick("to");
         if (i == WMAX) chk("to_before", 32'(obs_err), 32'd0);
         if (i == WMAX + 1) chk("to_rise", 32'(obs_err), 32'd1);
      end
      dmem_ready = 1'b1;
      tick("to_rdy");
      clr_in();
      tick("to_sticky");
      chk("to_sticky", 32'(obs_err), 32'd1);
      rst = 1'b1;
      tick("to_rst");
      rst = 1'b0;
      tick("to_clr");
      chk("to_clr", 32'(obs_err), 32'd0);

      // Reset in the middle of MD_WAIT.
      MulDiv_ex = 1'b1;
      tick("rmd0");
      tick("rmd1");
      rst = 1'b1;
      tick("rmd_rst");
      chk("rmd_rst_outs", 32'(obs_ctrl), 32'(C_NONE));
      rst = 1'b0;
      tick("rmd_after");
      chk("rmd_after_outs", 32'(obs_ctrl), 32'(C_MD));
      clr_in();
      md_done = 1'b1;
      tick("rmd_done");
      clr_in();
      rst = 1'b1;
      tick("rmd_rst2");
      rst = 1'b0;
      tick("rmd_idle");
      chk("rmd_idle_busy", 32'(obs_busy), 32'd0);
      chk("rmd_idle_outs", 32'(obs_ctrl), 32'(C_NONE));

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(99) == 0);
         MemRead_ex     = ($urandom_range(2) == 0);
         rdAddr_ex      = 5'($urandom_range(3));
         rs1Addr_id     = 5'($urandom_range(3));
         rs2Addr_id     = 5'($urandom_range(3));
         rs1Used_id     = 1'($urandom_range(1));
         rs2Used_id     = 1'($urandom_range(1));
         BranchTaken_ex = ($urandom_range(5) == 0);
         MulDiv_ex      = ($urandom_range(7) == 0);
         md_done        = ($urandom_range(3) == 0);
         dmem_req_mem   = ($urandom_range(2) == 0);
         dmem_ready     = ($urandom_range(i % 500 < 60 ? 9 : 1) == 0);
         tick("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Consumes hazard conditions from ID, EX and MEM: load-use, taken branch/jump, multi-cycle MUL/DIV, and data-memory wait. Drives per-stage hold and bubble controls to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the start pulse of the MUL/DIV unit. Complements the forwarding unit: this block covers every hazard that forwarding cannot resolve.

## Interface
Parameters:
- WAIT_MAX, 255, cycles in a wait state before wait_err is raised (≥1)

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- MemRead_ex  in  1  EX instruction is a load
- rdAddr_ex  in  5  EX destination register
- rs1Addr_id, rs2Addr_id  in  5 each  ID source registers
- rs1Used_id, rs2Used_id  in  1 each  ID instruction reads rs1/rs2
- BranchTaken_ex  in  1  EX resolved a taken branch/jump (PC redirect this cycle)
- MulDiv_ex  in  1  EX holds a MUL/DIV instruction
- md_done  in  1  MUL/DIV result valid this cycle
- dmem_req_mem  in  1  MEM stage issues a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- Stall_if, Stall_id, Stall_ex, Stall_mem  out  1 each  hold PC / IF/ID / ID/EX / EX/MEM
- Flush_id, Flush_ex, Flush_mem, Flush_wb  out  1 each  load a bubble into IF/ID / ID/EX / EX/MEM / MEM/WB
- md_start  out  1  one-cycle start pulse to the MUL/DIV unit
- busy  out  1  FSM is not in RUN
- wait_err  out  1  sticky: a wait exceeded WAIT_MAX cycles

## Operation
- FSM states: RUN, MD_WAIT, MEM_WAIT. Every Stall/Flush output and md_start is combinational from state and inputs.
- RUN evaluates rules in strict priority order; only the first matching rule acts:
  1. Memory wait (dmem_req_mem && !dmem_ready): Stall_if/id/ex/mem=1, Flush_wb=1; next state MEM_WAIT.
  2. Multi-cycle op (MulDiv_ex): md_start=1, Stall_if/id/ex=1, Flush_mem=1; next state MD_WAIT.
  3. Redirect (BranchTaken_ex): Flush_id=1, Flush_ex=1; no stall.
  4. Load-use (MemRead_ex && rdAddr_ex≠0 && ((rs1Used_id && rs1Addr_id==rdAddr_ex) || (rs2Used_id && rs2Addr_id==rdAddr_ex))): Stall_if=1, Stall_id=1, Flush_ex=1. Exactly one bubble.
- MEM_WAIT:
  - While dmem_ready=0: same outputs as RUN rule 1.
  - In the cycle dmem_ready=1: outputs follow RUN rules 2–4 with rule 1 disabled. Next state is chosen the same way: MD_WAIT if rule 2 fires, else RUN.
- MD_WAIT:
  - While md_done=0: Stall_if/id/ex=1, Flush_mem=1, md_start=0.
  - In the cycle md_done=1: all outputs 0, so the result is captured into EX/MEM. Next state RUN.
- Wait counter (width clog2(WAIT_MAX+1)):
  - Cleared on every transition into MEM_WAIT or MD_WAIT.
  - Increments each cycle spent in a wait state; saturates at WAIT_MAX.
  - Reaching WAIT_MAX sets wait_err. wait_err clears only on rst.
  - Stalling continues regardless of wait_err.
- Register x0 never causes a load-use stall.
- Branch and load-use in the same cycle: branch wins; the dependent ID instruction is flushed, so no stall occurs.

## Timing
- Reset:
  - State RUN, counter 0, wait_err 0.
  - While rst=1, all Stall/Flush outputs, md_start and busy are forced 0.
- Stall/flush latency: zero; asserted in the same cycle as the causing condition.
- md_start: exactly one cycle per MUL/DIV instruction, including the MEM_WAIT exit path.
- md_done in the same cycle as md_start is ignored; the unit must take at least 1 cycle.
- Load-use costs 1 cycle. Taken branch costs 2 bubbles. MUL/DIV stall equals cycles from md_start until md_done. Memory stall equals cycles until dmem_ready.
- busy is registered (state≠RUN) and rises the cycle after entry into a wait state.
- rst asserted mid-wait: the FSM is back in RUN on the next edge, with no md_start and no pending flush.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum {RUN, MD_WAIT, MEM_WAIT}
  - localparam REG_X0 = 5'd0
- Sub-module wait_timer (parameter WAIT_MAX; inputs clk, rst, clear, count; output sticky err) encapsulates the counter and the sticky flag.
- The load-use compare stays inline.

## Test plan
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Used_id=1, rs2Addr_id=5 for one cycle → Stall_if=Stall_id=Flush_ex=1 for exactly 1 cycle. Repeat with rdAddr_ex=0 → no stall.
- Branch + load-use together: BranchTaken_ex=1 with a matching load-use → Flush_id=Flush_ex=1, Stall_if=0.
- MUL/DIV: MulDiv_ex=1, md_done after 4 cycles → md_start pulse in cycle 0; Stall_if/id/ex=1 and Flush_mem=1 in cycles 0–3; all outputs 0 in cycle 4; busy high in cycles 1–4.
- Memory wait then MUL/DIV: dmem_req_mem=1, dmem_ready=0 for 3 cycles, then 1, with MulDiv_ex=1 throughout → Flush_wb=1 for 3 cycles; md_start fires only in the ready cycle; then MD_WAIT.
- Timeout: WAIT_MAX=8, dmem_ready held 0 → wait_err rises after 8 wait cycles and stays high after dmem_ready=1, until rst.
- Reset mid-MD_WAIT: rst for 1 cycle → next cycle state RUN, busy=0, all stalls 0, wait_err=0.
